// File: rtl/i2s_tx.sv
// I2S / left-justified stereo serial transmitter with a one-frame holding buffer,
// programmable BCK divide, mute sampled at frame start and underrun reporting.
module i2s_tx #(
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32,
  parameter int BCK_DIV = 1,
  parameter int FORMAT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] left_data,
  input  logic [DATA_W-1:0] right_data,
  input  logic              mute,
  output logic              underrun,
  output logic              i2s_lrck,
  output logic              i2s_bck,
  output logic              i2s_data
);

  localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int CNT_W = $clog2(SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_W - 1);

  if (DATA_W < 1 || DATA_W > SLOT_W) begin : g_bad_data_w
    $error("i2s_tx: DATA_W must be in 1..SLOT_W");
  end
  if (SLOT_W < 2 || SLOT_W > 64) begin : g_bad_slot_w
    $error("i2s_tx: SLOT_W must be in 2..64");
  end
  if (BCK_DIV < 1 || BCK_DIV > 255) begin : g_bad_bck_div
    $error("i2s_tx: BCK_DIV must be in 1..255");
  end
  if (FORMAT != 0 && FORMAT != 1) begin : g_bad_format
    $error("i2s_tx: FORMAT must be 0 (I2S) or 1 (left-justified)");
  end
  if (FORMAT == 0 && SLOT_W == DATA_W) begin : g_bad_i2s_slot
    $error("i2s_tx: I2S format needs SLOT_W > DATA_W for the one-bit delay");
  end

  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic              full;
  logic [DATA_W-1:0] buf_l;
  logic [DATA_W-1:0] buf_r;
  logic [DATA_W-1:0] word_r;
  logic [DATA_W-1:0] shreg;

  logic              tick;
  logic              fall;
  logic              slot_end;
  logic              frame_start;
  logic              xfer;
  logic [DATA_W-1:0] load_l;
  logic [DATA_W-1:0] load_r;
  logic [DATA_W-1:0] slot_word;

  always_comb begin
    tick        = (div_cnt == DIV_LAST);
    fall        = tick & i2s_bck;
    slot_end    = (bit_cnt == CNT_LAST);
    frame_start = fall & slot_end & i2s_lrck;
    xfer        = sample_valid & ~full;
    load_l      = (full & ~mute) ? buf_l : '0;
    load_r      = (full & ~mute) ? buf_r : '0;
    // lrck still 1 here means the slot about to start is the left one
    slot_word   = i2s_lrck ? load_l : word_r;
  end

  assign sample_ready = ~full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      i2s_bck <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      i2s_bck <= ~i2s_bck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // The shift register is reloaded at each slot start; after DATA_W shifts it
  // drains to zero, which provides the trailing zero padding of the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= CNT_LAST;
      i2s_lrck <= 1'b1;
      i2s_data <= 1'b0;
      shreg    <= '0;
      word_r   <= '0;
    end else if (fall) begin
      if (slot_end) begin
        bit_cnt  <= '0;
        i2s_lrck <= ~i2s_lrck;
        if (FORMAT == 1) begin
          i2s_data <= slot_word[DATA_W-1];
          shreg    <= slot_word << 1;
        end else begin
          i2s_data <= 1'b0;
          shreg    <= slot_word;
        end
        if (i2s_lrck) begin
          word_r <= load_r;
        end
      end else begin
        bit_cnt  <= bit_cnt + 1'b1;
        i2s_data <= shreg[DATA_W-1];
        shreg    <= shreg << 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      buf_l    <= '0;
      buf_r    <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= frame_start & ~full;
      if (xfer) begin
        full  <= 1'b1;
        buf_l <= left_data;
        buf_r <= right_data;
      end else if (frame_start) begin
        full <= 1'b0;
      end
    end
  end

endmodule
